// File: rtl/usb4_logical_lane_core_if.sv
// Config bus, transport byte streams and lane byte streams of usb4_logical_lane_core.
// master = transport/config host and electrical-layer stub, slave = the lane core.
interface usb4_logical_lane_core_if;
  logic        c_read;
  logic        c_write;
  logic [7:0]  c_address;
  logic [31:0] c_data_in;
  logic [31:0] c_data_out;
  logic [7:0]  transport_layer_data_in;
  logic [7:0]  transport_layer_data_out;
  logic [7:0]  lane_0_rx_i;
  logic [7:0]  lane_1_rx_i;
  logic        data_incoming;
  logic [7:0]  lane_0_tx_o;
  logic [7:0]  lane_1_tx_o;

  modport master (
    output c_read, c_write, c_address, c_data_in,
    output transport_layer_data_in, lane_0_rx_i, lane_1_rx_i, data_incoming,
    input  c_data_out, transport_layer_data_out, lane_0_tx_o, lane_1_tx_o
  );

  modport slave (
    input  c_read, c_write, c_address, c_data_in,
    input  transport_layer_data_in, lane_0_rx_i, lane_1_rx_i, data_incoming,
    output c_data_out, transport_layer_data_out, lane_0_tx_o, lane_1_tx_o
  );
endinterface

// File: rtl/usb4_logical_lane_core.sv
// Simplified USB4 logical-layer lane controller: sideband-gated training, CL0 data
// transfer and a small config register file. Define DUAL_LANE_EN for two-lane striping.
module usb4_logical_lane_core #(
  parameter logic [7:0] TRAIN_OS    = 8'hC5,
  parameter int         TRAIN_LEN   = 16,
  parameter int         SB_DEBOUNCE = 4
) (
  input  logic local_clk,
  input  logic rst,
  input  logic lane_disable,
  input  logic sbtx,
  output logic sbrx,
  output logic enable_scr,
  usb4_logical_lane_core_if.slave bus
);
  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    CLD      = 2'd1,
    TRAINING = 2'd2,
    CL0      = 2'd3
  } state_t;

  localparam int SB_W = $clog2(SB_DEBOUNCE + 1);
  localparam int TR_W = $clog2(TRAIN_LEN + 1);

  state_t          state;
  state_t          state_next;
  logic [SB_W-1:0] sb_cnt;
  logic [TR_W-1:0] tr_cnt;
  logic            ctrl_dis;
  logic [31:0]     scratch;
  logic [31:0]     rx_cnt;
  logic            dis;
  logic            train_ok;
  logic            train_bad;
  logic            rx_take;

  assign dis        = lane_disable | ctrl_dis;
  assign enable_scr = 1'b0;

`ifdef DUAL_LANE_EN
  logic tx_sel;
  logic rx_sel;
  assign train_ok = bus.data_incoming && (bus.lane_0_rx_i == TRAIN_OS) &&
                    (bus.lane_1_rx_i == TRAIN_OS);
`else
  logic unused_lane_1;
  assign unused_lane_1 = ^bus.lane_1_rx_i;
  assign train_ok = bus.data_incoming && (bus.lane_0_rx_i == TRAIN_OS);
`endif

  assign train_bad = bus.data_incoming && !train_ok;
  assign rx_take   = (state == CL0) && bus.data_incoming;

  // Disable overrides everything; a lost sideband drops back to CLD.
  always_comb begin
    state_next = state;
    if (dis) begin
      state_next = DISABLED;
    end else begin
      case (state)
        DISABLED: state_next = CLD;
        CLD: begin
          if (sbtx && (sb_cnt == SB_W'(SB_DEBOUNCE - 1))) state_next = TRAINING;
        end
        TRAINING: begin
          if (!sbtx) state_next = CLD;
          else if (train_ok && (tr_cnt == TR_W'(TRAIN_LEN - 1))) state_next = CL0;
        end
        CL0: begin
          if (!sbtx) state_next = CLD;
        end
        default: state_next = DISABLED;
      endcase
    end
  end

  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      state                        <= DISABLED;
      sb_cnt                       <= '0;
      tr_cnt                       <= '0;
      sbrx                         <= 1'b0;
      bus.lane_0_tx_o              <= 8'h00;
      bus.lane_1_tx_o              <= 8'h00;
      bus.transport_layer_data_out <= 8'h00;
      bus.c_data_out               <= 32'h0;
      ctrl_dis                     <= 1'b0;
      scratch                      <= 32'h0;
      rx_cnt                       <= 32'h0;
`ifdef DUAL_LANE_EN
      tx_sel                       <= 1'b0;
      rx_sel                       <= 1'b0;
`endif
    end else begin
      state <= state_next;
      sbrx  <= (state_next != DISABLED);

      sb_cnt <= (state == CLD && state_next == CLD && sbtx) ? sb_cnt + SB_W'(1) : '0;

      if (state == TRAINING && state_next == TRAINING) begin
        if (train_ok)       tr_cnt <= tr_cnt + TR_W'(1);
        else if (train_bad) tr_cnt <= '0;
      end else begin
        tr_cnt <= '0;
      end

      // Lane outputs follow the state being entered, so they line up with sbrx.
      bus.lane_0_tx_o <= 8'h00;
      bus.lane_1_tx_o <= 8'h00;
      if (state_next == TRAINING) begin
        bus.lane_0_tx_o <= TRAIN_OS;
`ifdef DUAL_LANE_EN
        bus.lane_1_tx_o <= TRAIN_OS;
`endif
      end else if (state == CL0 && state_next == CL0) begin
`ifdef DUAL_LANE_EN
        if (tx_sel) bus.lane_1_tx_o <= bus.transport_layer_data_in;
        else        bus.lane_0_tx_o <= bus.transport_layer_data_in;
`else
        bus.lane_0_tx_o <= bus.transport_layer_data_in;
`endif
      end

`ifdef DUAL_LANE_EN
      if (state == CL0) begin
        tx_sel <= ~tx_sel;
        if (bus.data_incoming) rx_sel <= ~rx_sel;
      end else begin
        tx_sel <= 1'b0;
        rx_sel <= 1'b0;
      end
      if (rx_take) bus.transport_layer_data_out <= rx_sel ? bus.lane_1_rx_i : bus.lane_0_rx_i;
`else
      if (rx_take) bus.transport_layer_data_out <= bus.lane_0_rx_i;
`endif

      // Reads sample pre-write contents, so a same-cycle write is not visible yet.
      if (bus.c_read) begin
        case (bus.c_address)
          8'h00:   bus.c_data_out <= {29'b0, sbtx, state};
          8'h04:   bus.c_data_out <= {31'b0, ctrl_dis};
          8'h08:   bus.c_data_out <= rx_cnt;
          8'h0C:   bus.c_data_out <= scratch;
          default: bus.c_data_out <= 32'h0;
        endcase
      end

      if (bus.c_write && bus.c_address == 8'h04) ctrl_dis <= bus.c_data_in[0];
      if (bus.c_write && bus.c_address == 8'h0C) scratch  <= bus.c_data_in;

      if (bus.c_write && bus.c_address == 8'h08) rx_cnt <= 32'h0;
      else if (rx_take)                          rx_cnt <= rx_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_usb4_logical_lane_core.sv
// Randomized bench for usb4_logical_lane_core against a cycle-level reference model
// of the link rules; directed link-up, striping and register scenarios come first.
module tb_usb4_logical_lane_core;
  localparam logic [7:0] OS          = 8'hC5;
  localparam int         TRAIN_LEN   = 16;
  localparam int         SB_DEBOUNCE = 4;
`ifdef DUAL_LANE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic local_clk = 1'b0;
  logic rst = 1'b1;
  logic lane_disable;
  logic sbtx;
  logic sbrx;
  logic enable_scr;

  usb4_logical_lane_core_if bus();

  usb4_logical_lane_core dut (
    .local_clk    (local_clk),
    .rst          (rst),
    .lane_disable (lane_disable),
    .sbtx         (sbtx),
    .sbrx         (sbrx),
    .enable_scr   (enable_scr),
    .bus          (bus)
  );

  always #5 local_clk = ~local_clk;

  int check_count = 0;
  int error_count = 0;

  // Reference model: link state as 0..3, run lengths and transfer counts as plain ints.
  int          m_state;
  int          m_sb_run;
  int          m_tr_run;
  int          m_tx_n;
  int          m_rx_n;
  bit          m_ctrl;
  logic [31:0] m_scratch;
  logic [31:0] m_rxcnt;
  logic        e_sbrx;
  logic [7:0]  e_l0;
  logic [7:0]  e_l1;
  logic [7:0]  e_out;
  logic [31:0] e_cdo;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_state = 0; m_sb_run = 0; m_tr_run = 0; m_tx_n = 0; m_rx_n = 0;
    m_ctrl = 1'b0; m_scratch = 32'h0; m_rxcnt = 32'h0;
    e_sbrx = 1'b0; e_l0 = 8'h00; e_l1 = 8'h00; e_out = 8'h00; e_cdo = 32'h0;
  endtask

  task automatic modelStep();
    int nxt;
    bit dis;
    bit good;
    bit take;
    dis  = lane_disable || m_ctrl;
    good = bus.data_incoming && bus.lane_0_rx_i == OS && (!DUAL || bus.lane_1_rx_i == OS);
    take = (m_state == 3) && bus.data_incoming;

    nxt = m_state;
    if (dis) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1) begin
      if (sbtx && m_sb_run + 1 == SB_DEBOUNCE) nxt = 2;
    end else if (m_state == 2) begin
      if (!sbtx) nxt = 1;
      else if (good && m_tr_run + 1 == TRAIN_LEN) nxt = 3;
    end else if (!sbtx) nxt = 1;

    if (bus.c_read) begin
      case (bus.c_address)
        8'h00:   e_cdo = (sbtx ? 32'd4 : 32'd0) + 32'(m_state);
        8'h04:   e_cdo = m_ctrl ? 32'd1 : 32'd0;
        8'h08:   e_cdo = m_rxcnt;
        8'h0C:   e_cdo = m_scratch;
        default: e_cdo = 32'h0;
      endcase
    end
    if (bus.c_write && bus.c_address == 8'h04) m_ctrl = bus.c_data_in[0];
    if (bus.c_write && bus.c_address == 8'h0C) m_scratch = bus.c_data_in;
    if (bus.c_write && bus.c_address == 8'h08) m_rxcnt = 32'h0;
    else if (take) m_rxcnt = m_rxcnt + 32'd1;

    if (take) begin
      e_out = (DUAL && (m_rx_n % 2 == 1)) ? bus.lane_1_rx_i : bus.lane_0_rx_i;
      m_rx_n++;
    end

    e_l0 = 8'h00;
    e_l1 = 8'h00;
    if (nxt == 2) begin
      e_l0 = OS;
      e_l1 = DUAL ? OS : 8'h00;
    end else if (m_state == 3 && nxt == 3) begin
      if (DUAL && (m_tx_n % 2 == 1)) e_l1 = bus.transport_layer_data_in;
      else                           e_l0 = bus.transport_layer_data_in;
    end
    if (m_state == 3) m_tx_n++;
    else begin
      m_tx_n = 0;
      m_rx_n = 0;
    end

    m_sb_run = (m_state == 1 && nxt == 1 && sbtx) ? m_sb_run + 1 : 0;
    if (m_state == 2 && nxt == 2) begin
      if (good) m_tr_run++;
      else if (bus.data_incoming) m_tr_run = 0;
    end else m_tr_run = 0;

    e_sbrx  = (nxt != 0);
    m_state = nxt;
  endtask

  task automatic compareAll();
    checkOutput("sbrx", 32'(sbrx), 32'(e_sbrx));
    checkOutput("lane0_tx", 32'(bus.lane_0_tx_o), 32'(e_l0));
    checkOutput("lane1_tx", 32'(bus.lane_1_tx_o), 32'(e_l1));
    checkOutput("rx_out", 32'(bus.transport_layer_data_out), 32'(e_out));
    checkOutput("c_data_out", bus.c_data_out, e_cdo);
    checkOutput("enable_scr", 32'(enable_scr), 32'h0);
  endtask

  task automatic tick();
    @(posedge local_clk);
    #1;
    if (rst) modelReset();
    else modelStep();
    compareAll();
  endtask

  task automatic applyStimulus(input logic dis, input logic sb, input logic di,
                               input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] din,
                               input logic rd, input logic wr, input logic [7:0] addr,
                               input logic [31:0] wdata);
    lane_disable                = dis;
    sbtx                        = sb;
    bus.data_incoming           = di;
    bus.lane_0_rx_i             = l0;
    bus.lane_1_rx_i             = l1;
    bus.transport_layer_data_in = din;
    bus.c_read                  = rd;
    bus.c_write                 = wr;
    bus.c_address               = addr;
    bus.c_data_in               = wdata;
    tick();
  endtask

  initial begin
    logic [7:0]  r_l0;
    logic [7:0]  r_l1;
    logic [7:0]  r_addr;
    logic [31:0] r_wd;
    modelReset();
    lane_disable = 1'b1; sbtx = 1'b1;
    bus.data_incoming = 1'b0; bus.lane_0_rx_i = 8'h00; bus.lane_1_rx_i = 8'h00;
    bus.transport_layer_data_in = 8'h00;
    bus.c_read = 1'b0; bus.c_write = 1'b0; bus.c_address = 8'h00; bus.c_data_in = 32'h0;

    repeat (3) tick();
    rst = 1'b0;

    repeat (49) applyStimulus(1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 32'h0);
    applyStimulus(1, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 32'h0);
    checkOutput("status_disabled", bus.c_data_out, 32'h4);
    checkOutput("sbrx_disabled", 32'(sbrx), 32'h0);

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 32'h0);
    checkOutput("cld_sbrx", 32'(sbrx), 32'h1);
    repeat (3) tick();
    checkOutput("cld_lane_idle", 32'(bus.lane_0_tx_o), 32'h0);
    tick();
    checkOutput("training_lane0", 32'(bus.lane_0_tx_o), 32'hC5);
    checkOutput("training_lane1", 32'(bus.lane_1_tx_o), DUAL ? 32'hC5 : 32'h0);

    repeat (10) applyStimulus(0, 1, 1, OS, OS, 8'h00, 0, 0, 8'h00, 32'h0);
    applyStimulus(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 32'h0);
    repeat (15) applyStimulus(0, 1, 1, OS, OS, 8'h00, 0, 0, 8'h00, 32'h0);
    checkOutput("train_not_done", 32'(bus.lane_0_tx_o), 32'hC5);
    applyStimulus(0, 1, 1, OS, OS, 8'h00, 0, 0, 8'h00, 32'h0);
    checkOutput("cl0_entry_lane0", 32'(bus.lane_0_tx_o), 32'h0);

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h11, 1, 0, 8'h00, 32'h0);
    checkOutput("status_cl0", bus.c_data_out, 32'h7);
    checkOutput("tx1_lane0", 32'(bus.lane_0_tx_o), 32'h11);
    checkOutput("tx1_lane1", 32'(bus.lane_1_tx_o), 32'h00);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h22, 0, 0, 8'h00, 32'h0);
    checkOutput("tx2_lane0", 32'(bus.lane_0_tx_o), DUAL ? 32'h00 : 32'h22);
    checkOutput("tx2_lane1", 32'(bus.lane_1_tx_o), DUAL ? 32'h22 : 32'h00);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h33, 0, 0, 8'h00, 32'h0);
    checkOutput("tx3_lane0", 32'(bus.lane_0_tx_o), 32'h33);
    checkOutput("tx3_lane1", 32'(bus.lane_1_tx_o), 32'h00);

    applyStimulus(0, 1, 1, 8'hAA, 8'hBB, 8'h00, 0, 0, 8'h00, 32'h0);
    checkOutput("rx1", 32'(bus.transport_layer_data_out), 32'hAA);
    applyStimulus(0, 1, 1, 8'hAA, 8'hBB, 8'h00, 0, 0, 8'h00, 32'h0);
    checkOutput("rx2", 32'(bus.transport_layer_data_out), DUAL ? 32'hBB : 32'hAA);
    applyStimulus(0, 1, 1, 8'hAA, 8'hBB, 8'h00, 0, 0, 8'h00, 32'h0);
    checkOutput("rx3", 32'(bus.transport_layer_data_out), 32'hAA);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h08, 32'h0);
    checkOutput("rxcnt_3", bus.c_data_out, 32'h3);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h08, 32'h5);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h08, 32'h0);
    checkOutput("rxcnt_cleared", bus.c_data_out, 32'h0);

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h0C, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 1, 8'h0C, 32'h12345678);
    checkOutput("scratch_rd", bus.c_data_out, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h0C, 32'h0);
    checkOutput("scratch_rd_after_wr", bus.c_data_out, 32'h12345678);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h40, 32'h0);
    checkOutput("unmapped_rd", bus.c_data_out, 32'h0);

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h04, 32'h1);
    checkOutput("ctrl_write_edge_sbrx", 32'(sbrx), 32'h1);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 32'h0);
    checkOutput("soft_disable_sbrx", 32'(sbrx), 32'h0);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 32'h0);
    checkOutput("soft_disable_status", bus.c_data_out, 32'h4);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'h04, 32'h0);

    for (int i = 0; i < 800; i++) begin
      r_l0 = ($urandom_range(0, 19) == 0) ? 8'($urandom) : OS;
      r_l1 = ($urandom_range(0, 19) == 0) ? 8'($urandom) : OS;
      case ($urandom_range(0, 4))
        0:       r_addr = 8'h00;
        1:       r_addr = 8'h04;
        2:       r_addr = 8'h08;
        3:       r_addr = 8'h0C;
        default: r_addr = 8'($urandom);
      endcase
      r_wd = $urandom;
      if (r_addr == 8'h04) r_wd[0] = ($urandom_range(0, 9) == 0);
      applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 79) != 0),
                    1'($urandom_range(0, 1)), r_l0, r_l1, 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), r_addr, r_wd);
    end

    // Pull reset between clock edges and expect outputs to clear without a clock.
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("async_rst_sbrx", 32'(sbrx), 32'h0);
    checkOutput("async_rst_lane0", 32'(bus.lane_0_tx_o), 32'h0);
    checkOutput("async_rst_rx_out", 32'(bus.transport_layer_data_out), 32'h0);
    checkOutput("async_rst_cdo", bus.c_data_out, 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 32'h0);
    checkOutput("post_rst_status", bus.c_data_out, 32'h4);
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'h04, 32'h0);
    checkOutput("post_rst_ctrl", bus.c_data_out, 32'h0);
    repeat (6) applyStimulus(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 32'h0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end
endmodule
